// File: rtl/osc_intl_multi.sv
// Multi-channel peak-to-peak oscillation interlock: a shared window FSM drives
// per-channel min/max trackers, leaky counters and sticky trip flags.

module osc_intl_ch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              acc,
  input  logic              load,
  input  logic              eval,
  input  logic              update,
  input  logic              idle,
  input  logic              clr,
  input  logic              en,
  input  logic              mask,
  input  logic [DATA_W-1:0] thresh,
  input  logic [CNT_W-1:0]  cnt_thresh,
  output logic [DATA_W:0]   p2p,
  output logic [CNT_W-1:0]  cnt,
  output logic              flag
);
  logic signed [DATA_W-1:0] sd, mn, mx;
  logic signed [DATA_W:0]   mx_e, mn_e;

  assign sd   = data;
  assign mx_e = mx;
  assign mn_e = mn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mn <= '0;
      mx <= '0;
    end else if (acc) begin
      if (load) begin
        mn <= sd;
        mx <= sd;
      end else begin
        if (sd < mn) mn <= sd;
        if (sd > mx) mx <= sd;
      end
    end
  end

  // One extra bit makes max-min non-negative and wrap-free for any signed pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       p2p <= '0;
    else if (eval) p2p <= mx_e - mn_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || idle) begin
      cnt <= '0;
    end else if (update && mask) begin
      if (p2p >= {1'b0, thresh}) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
      end else begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      flag <= 1'b0;
    else if (clr) flag <= 1'b0;
    else if (cnt_thresh != '0 && mask && en && cnt >= cnt_thresh) flag <= 1'b1;
  end
endmodule

module osc_intl_multi #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_osc_en,
  input  logic                       i_clr,
  input  logic [NUM_CH*DATA_W-1:0]   i_data,
  input  logic                       i_data_valid,
  input  logic [NUM_CH-1:0]          i_ch_mask,
  input  logic [DATA_W-1:0]          i_data_thresh,
  input  logic [31:0]                i_period,
  input  logic [15:0]                i_cycle_cnt,
  input  logic [CNT_W-1:0]           i_cnt_thresh,
  output logic [NUM_CH-1:0]          o_osc_flag,
  output logic                       o_osc_any,
  output logic [NUM_CH*CNT_W-1:0]    o_osc_cnt,
  output logic [NUM_CH*(DATA_W+1)-1:0] o_p2p,
  output logic                       o_p2p_valid,
  output logic [2:0]                 o_state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    EVAL   = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] per_q, smp_cnt;
  logic [15:0] cyc_q, win_cnt;
  logic        idle, acc, last, load, eval, update;

  logic [NUM_CH-1:0][DATA_W-1:0] data_ch;
  logic [NUM_CH-1:0][DATA_W:0]   p2p_ch;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_ch;

  assign idle   = (state_q == IDLE);
  assign eval   = (state_q == EVAL);
  assign update = (state_q == UPDATE);
  assign acc    = (state_q == RUN) && i_data_valid && i_osc_en;
  assign load   = (smp_cnt == '0);
  assign last   = (smp_cnt == per_q - 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_osc_en) state_d = RUN;
      RUN:     if (acc && last) state_d = EVAL;
      EVAL:    state_d = UPDATE;
      UPDATE:  if (cyc_q != '0 && 16'(win_cnt + 16'd1) == cyc_q) state_d = DONE;
               else state_d = RUN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!i_osc_en) state_d = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Window length is frozen at run start so a live reprogram cannot split a window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_q   <= '0;
      cyc_q   <= '0;
      smp_cnt <= '0;
      win_cnt <= '0;
    end else if (idle) begin
      smp_cnt <= '0;
      win_cnt <= '0;
      if (i_osc_en) begin
        per_q <= (i_period == '0) ? 32'd1 : i_period;
        cyc_q <= i_cycle_cnt;
      end
    end else begin
      if (acc)    smp_cnt <= last ? '0 : smp_cnt + 32'd1;
      if (update) win_cnt <= win_cnt + 16'd1;
    end
  end

  assign data_ch = i_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    osc_intl_ch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
      .clk        (i_clk),
      .rst        (i_rst),
      .data       (data_ch[c]),
      .acc        (acc),
      .load       (load),
      .eval       (eval),
      .update     (update),
      .idle       (idle),
      .clr        (i_clr),
      .en         (i_osc_en),
      .mask       (i_ch_mask[c]),
      .thresh     (i_data_thresh),
      .cnt_thresh (i_cnt_thresh),
      .p2p        (p2p_ch[c]),
      .cnt        (cnt_ch[c]),
      .flag       (o_osc_flag[c])
    );
  end

  assign o_p2p       = p2p_ch;
  assign o_osc_cnt   = cnt_ch;
  assign o_osc_any   = |o_osc_flag;
  assign o_p2p_valid = update;
  assign o_state     = state_q;
endmodule

// File: tb/tb_osc_intl_multi.sv
// Directed bench for osc_intl_multi: stimulus pushes expected window results,
// a monitor pops and checks them on every o_p2p_valid pulse.

module tb_osc_intl_multi;
  localparam int NC = 4, DW = 32, CW = 16, PW = 33;

  logic              i_clk, i_rst, i_osc_en, i_clr, i_data_valid;
  logic [NC*DW-1:0]  i_data;
  logic [NC-1:0]     i_ch_mask;
  logic [DW-1:0]     i_data_thresh;
  logic [31:0]       i_period;
  logic [15:0]       i_cycle_cnt;
  logic [CW-1:0]     i_cnt_thresh;
  logic [NC-1:0]     o_osc_flag;
  logic              o_osc_any, o_p2p_valid;
  logic [NC*CW-1:0]  o_osc_cnt;
  logic [NC*PW-1:0]  o_p2p;
  logic [2:0]        o_state;

  osc_intl_multi #(.NUM_CH(NC), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_osc_en(i_osc_en), .i_clr(i_clr),
    .i_data(i_data), .i_data_valid(i_data_valid), .i_ch_mask(i_ch_mask),
    .i_data_thresh(i_data_thresh), .i_period(i_period), .i_cycle_cnt(i_cycle_cnt),
    .i_cnt_thresh(i_cnt_thresh), .o_osc_flag(o_osc_flag), .o_osc_any(o_osc_any),
    .o_osc_cnt(o_osc_cnt), .o_p2p(o_p2p), .o_p2p_valid(o_p2p_valid), .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [NC*PW-1:0] p2p;
    logic [NC*CW-1:0] cnt;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] dv(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  function automatic logic [NC*PW-1:0] pv(input logic [32:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  function automatic logic [NC*CW-1:0] cv(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic feed(input logic [NC*DW-1:0] d);
    i_data = d;
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
  endtask

  task automatic push(input logic [NC*PW-1:0] p, input logic [NC*CW-1:0] c);
    exp_t e;
    e.p2p = p;
    e.cnt = c;
    q.push_back(e);
  endtask

  // Counters land one cycle after the p2p_valid pulse.
  always @(negedge i_clk) begin
    if (o_p2p_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_p2p_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_p2p", o_p2p, e.p2p);
        @(negedge i_clk);
        chk("sb_cnt", o_osc_cnt, e.cnt);
      end
    end
  end

  logic [15:0] hi_tab [5];
  logic [15:0] ce_tab [5];

  initial begin
    i_rst = 1'b1; i_osc_en = 0; i_clr = 0; i_data = '0; i_data_valid = 0;
    i_ch_mask = '0; i_data_thresh = '0; i_period = '0; i_cycle_cnt = '0; i_cnt_thresh = '0;
    #12;
    chk("rst_state", o_state, 0);
    chk("rst_flag", o_osc_flag, 0);
    chk("rst_any", o_osc_any, 0);
    chk("rst_cnt", o_osc_cnt, 0);
    chk("rst_p2p", o_p2p, 0);
    chk("rst_p2p_valid", o_p2p_valid, 0);
    i_rst = 1'b0;
    step();

    // Basic two-window run, trip on second window
    i_period = 4; i_cycle_cnt = 2; i_data_thresh = 15; i_cnt_thresh = 2; i_ch_mask = 4'b0001;
    i_osc_en = 1; step();
    chk("run_entry", o_state, 1);
    for (int w = 1; w <= 2; w++) begin
      push(pv(15, 0, 0, 0), cv(16'(w), 0, 0, 0));
      feed(dv(-5, 0, 0, 0)); feed(dv(3, 0, 0, 0)); feed(dv(10, 0, 0, 0)); feed(dv(-2, 0, 0, 0));
      chk("eval_latency", o_state, 2);
      step();
      chk("update_pulse", o_p2p_valid, 1);
      step();
    end
    chk("done_state", o_state, 4);
    chk("flag_not_yet", o_osc_flag, 0);
    step();
    chk("flag_t4", o_osc_flag, 4'b0001);
    chk("any_t4", o_osc_any, 1);

    // Async reset while accumulating
    i_osc_en = 0; step();
    i_osc_en = 1; step();
    feed(dv(-5, 0, 0, 0)); feed(dv(3, 0, 0, 0));
    chk("flag_retained", o_osc_flag, 4'b0001);
    i_rst = 1'b1; #1;
    chk("arst_state", o_state, 0);
    chk("arst_flag", o_osc_flag, 0);
    chk("arst_p2p", o_p2p, 0);
    chk("arst_any", o_osc_any, 0);
    chk("arst_cnt", o_osc_cnt, 0);
    i_osc_en = 0; #1; i_rst = 1'b0;
    step();

    // Leaky up/down counter, continuous run
    hi_tab = '{16'd20, 16'd5, 16'd20, 16'd5, 16'd5};
    ce_tab = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd0};
    i_period = 2; i_cycle_cnt = 0; i_data_thresh = 10; i_cnt_thresh = 3; i_ch_mask = 4'b0001;
    i_osc_en = 1; step();
    for (int w = 0; w < 5; w++) begin
      push(pv({17'd0, hi_tab[w]}, 0, 0, 0), cv(ce_tab[w], 0, 0, 0));
      feed(dv(0, 0, 0, 0)); feed(dv({16'd0, hi_tab[w]}, 0, 0, 0));
      step(); step();
    end
    chk("leaky_no_trip", o_osc_flag, 0);
    chk("leaky_continuous", o_state, 1);
    i_osc_en = 0; step();

    // Signed extremes, masked channels hold counters, cnt_thresh 0 never trips
    i_period = 2; i_cycle_cnt = 1; i_data_thresh = 0; i_cnt_thresh = 0; i_ch_mask = 4'b0001;
    i_osc_en = 1; step();
    push(pv(0, 33'h0FFFFFFFF, 200, 1), cv(1, 0, 0, 0));
    feed(dv(0, 32'h7FFFFFFF, -100, 0));
    feed(dv(0, 32'h80000000, 100, -1));
    step(); step();
    chk("ext_done", o_state, 4);
    step();
    chk("cnt_thresh0_no_trip", o_osc_flag, 0);
    i_osc_en = 0; step();

    // Clear coincident with trip condition
    i_period = 1; i_cycle_cnt = 1; i_data_thresh = 0; i_cnt_thresh = 1; i_ch_mask = 4'b0001;
    i_osc_en = 1; step();
    push(pv(0, 0, 0, 0), cv(1, 0, 0, 0));
    feed(dv(7, 0, 0, 0));
    step(); step();
    i_clr = 1; step(); i_clr = 0;
    chk("clr_flag", o_osc_flag, 0);
    chk("clr_cnt", o_osc_cnt, 0);
    chk("clr_keeps_state", o_state, 4);
    step();
    chk("clr_flag_after", o_osc_flag, 0);
    i_osc_en = 0; step();

    // Enable drop mid-window discards it
    i_period = 4; i_cycle_cnt = 0; i_osc_en = 1; step();
    feed(dv(1, 0, 0, 0)); feed(dv(2, 0, 0, 0));
    i_osc_en = 0; step();
    chk("drop_idle", o_state, 0);
    repeat (4) step();
    chk("drop_no_pulse", o_p2p_valid, 0);

    // Sparse valid, period 3
    i_period = 3; i_cycle_cnt = 1; i_data_thresh = 0; i_cnt_thresh = 0; i_ch_mask = 4'b0001;
    i_osc_en = 1; step();
    push(pv(10, 0, 0, 0), cv(1, 0, 0, 0));
    feed(dv(1, 0, 0, 0)); step(); step();
    feed(dv(7, 0, 0, 0)); step(); step();
    chk("gap_still_run", o_state, 1);
    feed(dv(-3, 0, 0, 0));
    chk("gap_eval", o_state, 2);
    step(); step();
    chk("gap_done", o_state, 4);
    i_osc_en = 0; step();

    // Period 0 behaves as 1
    i_period = 0; i_cycle_cnt = 2; i_osc_en = 1; step();
    push(pv(0, 0, 0, 0), cv(1, 0, 0, 0));
    feed(dv(5, 0, 0, 0));
    chk("per0_eval", o_state, 2);
    step(); step();
    push(pv(0, 0, 0, 0), cv(2, 0, 0, 0));
    feed(dv(9, 0, 0, 0));
    step(); step();
    chk("per0_done", o_state, 4);
    i_osc_en = 0; step();

    repeat (3) step();
    chk("sb_empty", 192'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
